// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer: frame-buffered rate-1/2 K=3 convolutional encoder
// (G0=7, G1=5) with zero-tail termination and a decoder start strobe.
module conv_encoder_framer #(
  parameter int MAX_FRAME = 64,
  parameter bit TAIL_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       in_ready,
  output logic       sym_valid,
  output logic [1:0] sym_data,
  input  logic       sym_ready,
  output logic       dec_start,
  output logic       busy,
  output logic [6:0] sym_count
);

  localparam int MAX_DATA = TAIL_EN ? MAX_FRAME - 2 : MAX_FRAME;
  localparam int CW = $clog2(MAX_FRAME + 1);
  localparam int AW = $clog2(MAX_FRAME);
  localparam logic [CW-1:0] MAX_D = CW'(MAX_DATA);

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    TAIL,
    START
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [MAX_FRAME-1:0] r_buf;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        r_idx;
  logic [1:0]           r_s;
  logic                 r_tcnt;
  logic [6:0]           r_sym_count;

  logic w_accept;
  logic w_hs;
  logic w_b;
  logic w_full;
  logic w_last_data;

  assign w_accept    = in_valid && in_ready;
  assign w_hs        = sym_valid && sym_ready;
  assign w_full      = (r_count + CW'(1)) == MAX_D;
  assign w_last_data = r_idx == (r_count - CW'(1));
  assign sym_count   = r_sym_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      COLLECT: begin
        if (w_accept && (in_last || w_full)) begin
          w_next = EMIT;
        end
      end
      EMIT: begin
        if (w_hs && w_last_data) begin
          w_next = TAIL_EN ? TAIL : START;
        end
      end
      TAIL: begin
        if (w_hs && r_tcnt) begin
          w_next = START;
        end
      end
      START: begin
        w_next = COLLECT;
      end
      default: begin
        w_next = COLLECT;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    sym_valid = 1'b0;
    dec_start = 1'b0;
    busy      = 1'b1;
    w_b       = 1'b0;
    unique case (r_state)
      COLLECT: begin
        in_ready = r_count < MAX_D;
        busy     = 1'b0;
      end
      EMIT: begin
        sym_valid = 1'b1;
        w_b       = r_buf[r_idx[AW-1:0]];
      end
      TAIL: begin
        sym_valid = 1'b1;
      end
      START: begin
        dec_start = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    // s[1] is the oldest bit; idle symbol lines stay at zero
    sym_data = 2'b00;
    if (sym_valid) begin
      sym_data = {w_b ^ r_s[1] ^ r_s[0], w_b ^ r_s[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_s         <= 2'b00;
      r_tcnt      <= 1'b0;
      r_sym_count <= 7'd0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_buf[r_count[AW-1:0]] <= in_bit;
            r_count <= r_count + CW'(1);
          end
        end
        EMIT: begin
          if (w_hs) begin
            r_s   <= {r_s[0], w_b};
            r_idx <= r_idx + CW'(1);
            // first symbol of a frame restarts the count
            if (r_idx == '0) begin
              r_sym_count <= 7'd1;
            end else begin
              r_sym_count <= r_sym_count + 7'd1;
            end
          end
        end
        TAIL: begin
          if (w_hs) begin
            r_s         <= {r_s[0], 1'b0};
            r_tcnt      <= ~r_tcnt;
            r_sym_count <= r_sym_count + 7'd1;
          end
        end
        START: begin
          r_count <= '0;
          r_idx   <= '0;
          r_s     <= 2'b00;
          r_tcnt  <= 1'b0;
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// tb_conv_encoder_framer: table vectors plus randomized frames checked
// against a convolution model; two instances cover TAIL_EN=1 and TAIL_EN=0.
module tb_conv_encoder_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_bit, in_last, sym_ready, en0;
  logic b_in_valid;
  assign b_in_valid = in_valid && en0;

  logic       a_in_ready, a_sym_valid, a_dec_start, a_busy;
  logic [1:0] a_sym_data;
  logic [6:0] a_sym_count;
  logic       b_in_ready, b_sym_valid, b_dec_start, b_busy;
  logic [1:0] b_sym_data;
  logic [6:0] b_sym_count;

  conv_encoder_framer #(.MAX_FRAME(64), .TAIL_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_last(in_last), .in_ready(a_in_ready), .sym_valid(a_sym_valid),
    .sym_data(a_sym_data), .sym_ready(sym_ready),
    .dec_start(a_dec_start), .busy(a_busy), .sym_count(a_sym_count)
  );

  conv_encoder_framer #(.MAX_FRAME(64), .TAIL_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_bit(in_bit),
    .in_last(in_last), .in_ready(b_in_ready), .sym_valid(b_sym_valid),
    .sym_data(b_sym_data), .sym_ready(sym_ready),
    .dec_start(b_dec_start), .busy(b_busy), .sym_count(b_sym_count)
  );

  typedef struct {
    int              n;
    logic [0:7]      bits;
    logic [0:5][1:0] exp;
  } vec_t;

  vec_t tv[5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  int da = 0, db = 0, da0 = 0, db0 = 0;
  int a_hs_cyc = 0, a_st_cyc = 0, b_hs_cyc = 0, b_st_cyc = 0;
  int overlap_err = 0, hold_err = 0, acc_err = 0;
  logic pa_stall = 1'b0, pb_stall = 1'b0;
  logic [1:0] pa_d = 2'b00, pb_d = 2'b00;
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    sym_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: sym_ready = 1'b1;
        1: sym_ready = (cyc % 3 == 0);
        default: sym_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pa_stall && (!a_sym_valid || a_sym_data != pa_d)) hold_err++;
      if (pb_stall && (!b_sym_valid || b_sym_data != pb_d)) hold_err++;
    end
    pa_stall = a_sym_valid && !sym_ready;
    pa_d     = a_sym_data;
    pb_stall = b_sym_valid && !sym_ready;
    pb_d     = b_sym_data;
    if (a_sym_valid && sym_ready) begin
      qa.push_back(a_sym_data);
      a_hs_cyc = cyc;
    end
    if (b_sym_valid && sym_ready) begin
      qb.push_back(b_sym_data);
      b_hs_cyc = cyc;
    end
    if (a_dec_start) begin
      da++;
      a_st_cyc = cyc;
      if (a_sym_valid) overlap_err++;
    end
    if (b_dec_start) begin
      db++;
      b_st_cyc = cyc;
      if (b_sym_valid) overlap_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input int n, input bit last);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = d[i];
      in_last  = last && (i == n - 1);
      @(negedge clk);
      if (!a_in_ready) acc_err++;
      if (en0 && !b_in_ready) acc_err++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input bit need_b, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(negedge clk);
      ok = (da == da0 + 1) && (!need_b || db == db0 + 1) &&
           !a_busy && !b_busy;
    end
    chk({nm, " done"}, int'(ok), 1);
  endtask

  // reference: convolve the zero-padded bit stream with 111 and 101
  task automatic build(input logic [63:0] d, input int n, input bit tail);
    int u[$];
    int tot;
    int g0, g1, u1, u2;
    exp_q.delete();
    tot = n + (tail ? 2 : 0);
    for (int t = 0; t < tot; t++) u.push_back(t < n ? int'(d[t]) : 0);
    for (int t = 0; t < tot; t++) begin
      u1 = (t >= 1) ? u[t-1] : 0;
      u2 = (t >= 2) ? u[t-2] : 0;
      g0 = (u[t] + u1 + u2) % 2;
      g1 = (u[t] + u2) % 2;
      exp_q.push_back(2'(g0 * 2 + g1));
    end
  endtask

  task automatic cmp_frame(input string nm, input bit sel_b);
    int n;
    int got;
    n = sel_b ? qb.size() : qa.size();
    chk({nm, " len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      got = sel_b ? int'(qb[i]) : int'(qa[i]);
      chk($sformatf("%s sym%0d", nm, i), got, int'(exp_q[i]));
    end
  endtask

  task automatic start_frame();
    qa.delete();
    qb.delete();
    da0 = da;
    db0 = db;
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  s;
    logic        bb;
    int          n, bad, d0;

    tv[0] = '{4, 8'b10110000, {2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3}};
    tv[1] = '{2, 8'b11000000, {2'd3, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0}};
    tv[2] = '{3, 8'b00100000, {2'd0, 2'd0, 2'd3, 2'd2, 2'd3, 2'd0}};
    tv[3] = '{1, 8'b10000000, {2'd3, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0}};
    tv[4] = '{4, 8'b11110000, {2'd3, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3}};

    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; en0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", a_in_ready, 1);
    chk("rst sym_valid", a_sym_valid, 0);
    chk("rst sym_data", a_sym_data, 0);
    chk("rst dec_start", a_dec_start, 0);
    chk("rst busy", a_busy, 0);
    chk("rst sym_count", a_sym_count, 0);
    chk("rst b in_ready", b_in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    mode = 0;
    for (int e = 0; e < 5; e++) begin
      start_frame();
      d = '0;
      for (int i = 0; i < tv[e].n; i++) d[i] = tv[e].bits[i];
      send(d, tv[e].n, 1'b1);
      wait_done(1'b1, $sformatf("tv%0d", e));
      exp_q.delete();
      for (int i = 0; i < tv[e].n + 2; i++) exp_q.push_back(tv[e].exp[i]);
      cmp_frame($sformatf("tv%0d tail", e), 1'b0);
      chk($sformatf("tv%0d count", e), a_sym_count, tv[e].n + 2);
      chk($sformatf("tv%0d start lat", e), a_st_cyc - a_hs_cyc, 1);
      exp_q.delete();
      for (int i = 0; i < tv[e].n; i++) exp_q.push_back(tv[e].exp[i]);
      cmp_frame($sformatf("tv%0d notail", e), 1'b1);
      chk($sformatf("tv%0d b count", e), b_sym_count, tv[e].n);
      chk($sformatf("tv%0d b start lat", e), b_st_cyc - b_hs_cyc, 1);
    end

    mode = 1;
    start_frame();
    d = 64'hD;
    send(d, 4, 1'b1);
    wait_done(1'b1, "stall");
    build(d, 4, 1'b1);
    cmp_frame("stall tail", 1'b0);
    build(d, 4, 1'b0);
    cmp_frame("stall notail", 1'b1);
    chk("stall hold", hold_err, 0);

    mode = 0;
    en0 = 1'b0;
    start_frame();
    d = {$urandom, $urandom};
    send(d, 62, 1'b0);
    @(negedge clk);
    chk("max in_ready drop", a_in_ready, 0);
    chk("max busy", a_busy, 1);
    in_valid = 1'b1;
    in_bit = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_done(1'b0, "max");
    build(d, 62, 1'b1);
    cmp_frame("max", 1'b0);
    chk("max count", a_sym_count, 64);
    en0 = 1'b1;

    start_frame();
    d = 64'hD;
    send(d, 4, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst mid syms", qa.size(), 2);
    d0 = da;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst mid sym_valid", a_sym_valid, 0);
    chk("rst mid in_ready", a_in_ready, 1);
    chk("rst mid busy", a_busy, 0);
    repeat (5) @(negedge clk);
    chk("rst mid no start", da, d0);
    start_frame();
    d = 64'h3;
    send(d, 2, 1'b1);
    wait_done(1'b1, "post rst");
    build(d, 2, 1'b1);
    cmp_frame("post rst", 1'b0);
    build(d, 2, 1'b0);
    cmp_frame("post rst b", 1'b1);

    mode = 2;
    for (int f = 0; f < 8; f++) begin
      start_frame();
      n = $urandom_range(1, 20);
      d = {$urandom, $urandom};
      send(d, n, 1'b1);
      wait_done(1'b1, $sformatf("rnd%0d", f));
      build(d, n, 1'b1);
      cmp_frame($sformatf("rnd%0d", f), 1'b0);
      chk($sformatf("rnd%0d count", f), a_sym_count, n + 2);
      s = 2'b00;
      bad = 0;
      for (int i = 0; i < qa.size(); i++) begin
        bb = qa[i][0] ^ s[1];
        if (bb != ((i < n) ? d[i] : 1'b0)) bad++;
        s = {s[0], bb};
      end
      chk($sformatf("rnd%0d loopback", f), bad, 0);
      build(d, n, 1'b0);
      cmp_frame($sformatf("rnd%0d b", f), 1'b1);
      chk($sformatf("rnd%0d b count", f), b_sym_count, n);
    end

    chk("accept ready", acc_err, 0);
    chk("start overlap", overlap_err, 0);
    chk("hold total", hold_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
